// File: rtl/mpu_req_arbiter_pkg.sv
// Shared MPU front-end types: sizing, address/data/error types, arbiter FSM states.
// Pure definitions, no logic beyond the round-robin wrap helper.
package mpu_req_arbiter_pkg;

  localparam int CORE_COUNT          = 5;
  localparam int CORE_ID_WIDTH       = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam int ADDR_WIDTH          = 16;
  localparam int DATA_WIDTH          = 32;
  localparam int ARB_TIMEOUT_DEFAULT = 64;

  typedef logic [ADDR_WIDTH-1:0]    addr_bits_t;
  typedef logic [DATA_WIDTH-1:0]    data_bits_t;
  typedef logic [CORE_ID_WIDTH-1:0] core_id_t;

  typedef enum logic [1:0] {
    MPU_ERR_NONE  = 2'd0,
    MPU_ERR_PERM  = 2'd1,
    MPU_ERR_RANGE = 2'd2,
    MPU_ERR_FULL  = 2'd3
  } mpu_error_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  // CORE_COUNT need not be a power of two, so wrap by compare rather than truncation.
  function automatic core_id_t rr_next(input core_id_t idx);
    return (idx == core_id_t'(CORE_COUNT - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/mpu_req_arbiter_rr_arbiter.sv
// Round-robin pick over CORE_COUNT requesters: combinational grant, registered pointer.
// Zero-latency grant; pointer advances past the winner only when the caller takes it.
module mpu_req_arbiter_rr_arbiter
  import mpu_req_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CORE_COUNT-1:0] i_req,
  input  logic                  i_advance,
  output logic [CORE_COUNT-1:0] o_grant,
  output core_id_t              o_gnt_idx,
  output logic                  o_gnt_vld
);

  core_id_t                 r_ptr;
  logic [CORE_ID_WIDTH:0]   w_cand;
  core_id_t                 w_idx;

  // Scan offsets from the far end so the closest valid index to the pointer wins last.
  always_comb begin
    o_grant   = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_cand    = '0;
    w_idx     = '0;
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + (CORE_ID_WIDTH + 1)'(k);
      if (w_cand >= (CORE_ID_WIDTH + 1)'(CORE_COUNT)) begin
        w_cand = w_cand - (CORE_ID_WIDTH + 1)'(CORE_COUNT);
      end
      w_idx = w_cand[CORE_ID_WIDTH-1:0];
      if (i_req[w_idx]) begin
        o_gnt_idx = w_idx;
        o_gnt_vld = 1'b1;
      end
    end
    if (o_gnt_vld) begin
      o_grant[o_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_gnt_vld) begin
      r_ptr <= rr_next(o_gnt_idx);
    end
  end

endmodule

// File: rtl/mpu_req_arbiter.sv
// Serialises per-core MPU requests onto the single cs/cfg command port, one in flight.
// Grant->cs 1 cycle, then MPU latency or timeout; RESP holds until the owning core's rsp_ready.
module mpu_req_arbiter
  import mpu_req_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CORE_COUNT-1:0]            req_valid,
  output logic [CORE_COUNT-1:0]            req_ready,
  input  logic [CORE_COUNT-1:0]            req_cfg,
  input  logic [CORE_COUNT-1:0]            req_free_reserve,
  input  logic [CORE_COUNT-1:0]            req_we,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] req_addr,
  input  logic [CORE_COUNT*DATA_WIDTH-1:0] req_wdata,
  output logic [CORE_COUNT-1:0]            rsp_valid,
  input  logic [CORE_COUNT-1:0]            rsp_ready,
  output data_bits_t                       rsp_rdata,
  output mpu_error_t                       rsp_err,
  output logic                             rsp_timeout,
  output logic                             mpu_cs,
  output logic                             mpu_cfg,
  output logic                             mpu_free_reserve,
  output logic                             mpu_we,
  output core_id_t                         mpu_core_id,
  output addr_bits_t                       mpu_addr,
  output data_bits_t                       mpu_wdata,
  input  logic                             mpu_rdy,
  input  logic                             mpu_bsy,
  input  data_bits_t                       mpu_rdata,
  input  mpu_error_t                       mpu_err
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CORE_COUNT-1:0] r_gnt;
  core_id_t              r_gnt_idx;
  logic [CORE_COUNT-1:0] r_req_ready;
  logic [CORE_COUNT-1:0] r_rsp_valid;
  data_bits_t            r_rsp_rdata;
  mpu_error_t            r_rsp_err;
  logic                  r_rsp_timeout;
  logic                  r_mpu_cs;
  logic                  r_mpu_cfg;
  logic                  r_mpu_free_reserve;
  logic                  r_mpu_we;
  addr_bits_t            r_mpu_addr;
  data_bits_t            r_mpu_wdata;

  logic [CORE_COUNT-1:0] w_grant;
  core_id_t              w_gnt_idx;
  logic                  w_gnt_vld;
  logic                  w_take;
  addr_bits_t            w_addr_arr  [CORE_COUNT];
  data_bits_t            w_wdata_arr [CORE_COUNT];

  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_unpack
    assign w_addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_take = (r_state == ARB_IDLE) && w_gnt_vld && !mpu_bsy;

  mpu_req_arbiter_rr_arbiter u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_advance (w_take),
    .o_grant   (w_grant),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= ARB_IDLE;
      r_cnt              <= '0;
      r_gnt              <= '0;
      r_gnt_idx          <= '0;
      r_req_ready        <= '0;
      r_rsp_valid        <= '0;
      r_rsp_rdata        <= '0;
      r_rsp_err          <= MPU_ERR_NONE;
      r_rsp_timeout      <= 1'b0;
      r_mpu_cs           <= 1'b0;
      r_mpu_cfg          <= 1'b0;
      r_mpu_free_reserve <= 1'b0;
      r_mpu_we           <= 1'b0;
      r_mpu_addr         <= '0;
      r_mpu_wdata        <= '0;
    end else begin
      r_req_ready <= '0;
      r_mpu_cs    <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_take) begin
            r_req_ready        <= w_grant;
            r_gnt              <= w_grant;
            r_gnt_idx          <= w_gnt_idx;
            r_mpu_cfg          <= req_cfg[w_gnt_idx];
            r_mpu_free_reserve <= req_free_reserve[w_gnt_idx];
            r_mpu_we           <= req_we[w_gnt_idx];
            r_mpu_addr         <= w_addr_arr[w_gnt_idx];
            r_mpu_wdata        <= w_wdata_arr[w_gnt_idx];
            r_state            <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          r_mpu_cs <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ARB_WAIT;
        end
        ARB_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // rdy during the cs cycle itself belongs to no command of ours.
          if ((r_cnt != '0) && mpu_rdy) begin
            r_rsp_rdata   <= mpu_rdata;
            r_rsp_err     <= mpu_err;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= r_gnt;
            r_cnt         <= '0;
            r_state       <= ARB_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_rdata   <= '0;
            r_rsp_err     <= MPU_ERR_NONE;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= r_gnt;
            r_cnt         <= '0;
            r_state       <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (rsp_ready[r_gnt_idx]) begin
            r_rsp_valid <= '0;
            r_state     <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign req_ready        = r_req_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_err          = r_rsp_err;
  assign rsp_timeout      = r_rsp_timeout;
  assign mpu_cs           = r_mpu_cs;
  assign mpu_cfg          = r_mpu_cfg;
  assign mpu_free_reserve = r_mpu_free_reserve;
  assign mpu_we           = r_mpu_we;
  assign mpu_core_id      = r_gnt_idx;
  assign mpu_addr         = r_mpu_addr;
  assign mpu_wdata        = r_mpu_wdata;

endmodule

// File: doc/mpu_req_arbiter.md
Name: mpu_req_arbiter

Overview:
- Upstream front-end of the MPU. Accepts configure and access-check requests from CORE_COUNT cores over per-core valid/ready channels.
- Picks one request at a time by round-robin, stamps it with the true core_id (the port index) and drives the MPU's cs/cfg command interface.
- Waits for the MPU's rdy, then returns rdata/err to the requesting core over a per-core response channel.
- Cores cannot spoof core_id and never see the MPU's one-shot cs protocol.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the transaction is aborted with a timeout response.
- CORE_COUNT, CORE_ID_WIDTH, ADDR_WIDTH, DATA_WIDTH: taken from the shared package, not overridable.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req_valid  input  CORE_COUNT  per-core request present
- req_ready  output  CORE_COUNT  one-hot accept pulse, one cycle
- req_cfg  input  CORE_COUNT  per-core: 1 = configure, 0 = access check
- req_free_reserve  input  CORE_COUNT  per-core: 1 = reserve, 0 = release
- req_we  input  CORE_COUNT  per-core write flag
- req_addr  input  CORE_COUNT*ADDR_WIDTH  per-core addr_bits_t, core i at slice i
- req_wdata  input  CORE_COUNT*DATA_WIDTH  per-core data_bits_t
- rsp_valid  output  CORE_COUNT  one-hot response present
- rsp_ready  input  CORE_COUNT  per-core response accept
- rsp_rdata  output  DATA_WIDTH  response data, shared, qualified by rsp_valid
- rsp_err  output  mpu_error_t  MPU error code, shared
- rsp_timeout  output  1  response aborted by timeout
- mpu_cs, mpu_cfg, mpu_free_reserve, mpu_we  output  1 each  to MPU
- mpu_core_id  output  CORE_ID_WIDTH  to MPU
- mpu_addr  output  addr_bits_t  to MPU
- mpu_wdata  output  data_bits_t  to MPU
- mpu_rdy  input  1  from MPU rdy
- mpu_bsy  input  1  from MPU bsy
- mpu_rdata  input  DATA_WIDTH  from MPU
- mpu_err  input  mpu_error_t  from MPU

Behaviour:
- Reset values (async, any cycle): all outputs 0, err fields '0, state IDLE, round-robin pointer 0, timeout counter 0. Any in-flight transaction is dropped; no response is issued for it.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid and !mpu_bsy, grant the first valid index at or after the pointer, wrapping modulo CORE_COUNT.
  - Pulse req_ready[g] for that same cycle and latch the winner's fields plus g into command registers. Go to ISSUE.
  - Pointer becomes (g+1) mod CORE_COUNT.
  - If mpu_bsy is high, no grant.
- ISSUE: mpu_cs=1 for exactly one cycle, with the registered fields and mpu_core_id=g. Go to WAIT.
- WAIT:
  - The counter increments each cycle. mpu_rdy is ignored in the first WAIT cycle (rdy is sampled from the 2nd posedge after the cs edge onward).
  - On mpu_rdy=1: capture mpu_rdata/mpu_err, set rsp_timeout=0, go to RESP.
  - On counter == TIMEOUT_CYCLES-1 without rdy: rsp_rdata='0, rsp_err='0, rsp_timeout=1, go to RESP.
- RESP: rsp_valid[g]=1 and rsp fields held stable until rsp_ready[g]=1. On that posedge, clear rsp_valid and go to IDLE. No new grant is made in the same cycle.
- Request fields must be stable while req_valid is high. A request may drop before acceptance with no effect.
- Minimum throughput: one transaction per 4 cycles plus MPU latency. Only one transaction is outstanding.
- Simultaneous req and rsp on the same core: the core's new request waits until after RESP.
- CORE_COUNT not a power of 2: the wrap is an explicit compare, not bit truncation.

Decomposition:
- Shared package (existing mpu_common.svh) gets arb_state_t (the FSM enum) and ARB_TIMEOUT_DEFAULT. Reuse CORE_COUNT, CORE_ID_WIDTH, addr_bits_t, data_bits_t, mpu_error_t.
- One sub-module: rr_arbiter, a combinational round-robin pick plus registered pointer, CORE_COUNT-wide, outputting the one-hot grant and the encoded index.

Test Plan:
- Reset: assert rst mid-WAIT -> all outputs 0 on the same cycle; after release, no rsp_valid and the pointer restarts at 0.
- Single reserve: core 2 requests cfg=1, free_reserve=1, size=4 -> req_ready[2] pulse, mpu_cs one cycle with core_id=2. Model rdy after 3 cycles with rdata=0x40 -> rsp_valid[2], rsp_rdata=0x40, rsp_timeout=0.
- Fairness: cores 0, 1, 3 hold req_valid continuously -> grant order 0,1,3,0,1,3. No core is granted twice before another valid core.
- Busy gating: mpu_bsy=1 with core 1 valid -> no req_ready and no cs. Drop bsy -> grant on the next cycle.
- Timeout: TIMEOUT_CYCLES=8, MPU never raises rdy -> rsp_valid[g] exactly 8 cycles after the ISSUE cycle, with rsp_timeout=1 and rsp_err='0.
- Backpressure: hold rsp_ready[1]=0 for 5 cycles while core 0 is valid -> rsp fields stable, core 0 not granted until the cycle after rsp_ready[1]=1.
